// File: rtl/ais_slot_scheduler.sv
// AIS TDMA slot scheduler: minute-aligned slot timer, two-requester slot
// arbitration, transmitter start/busy supervision and per-requester completion status.
`timescale 1ns/1ps
module ais_slot_scheduler #(
    parameter int SLOT_CLKS       = 1333333,
    parameter int SLOTS_PER_FRAME = 2250,
    parameter int START_TIMEOUT   = 1000,
    parameter int MAX_TX_SLOTS    = 5,
    parameter int REQUIRE_SYNC    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sync_pulse,
    // Handshake: req[i] is a level held with a stable req_slotI until ack[i]
    // pulses for one cycle (ack_status valid only then); the requester drops
    // req[i] the cycle after its ack.
    input  logic [1:0]  req,
    input  logic [11:0] req_slot0,
    input  logic [11:0] req_slot1,
    output logic [1:0]  ack,
    output logic [1:0]  ack_status,
    output logic        tx_start,
    output logic        tx_sel,
    output logic        tx_abort,
    input  logic        tx_busy,
    output logic [11:0] slot_num,
    output logic        slot_tick,
    output logic        sync_locked,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        TX        = 2'd3
    } state_t;

    localparam logic [1:0] ST_SENT    = 2'b00;
    localparam logic [1:0] ST_MISS    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_ABORT   = 2'b11;

    localparam int CLK_W = $clog2(SLOT_CLKS);
    localparam int TO_W  = $clog2(START_TIMEOUT + 1);
    localparam int OV_W  = $clog2(MAX_TX_SLOTS + 1);

    localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(SLOT_CLKS - 1);
    localparam logic [11:0]      SLOT_LAST = 12'(SLOTS_PER_FRAME - 1);
    localparam logic [12:0]      SLOT_LIM  = 13'(SLOTS_PER_FRAME);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(START_TIMEOUT - 1);
    localparam logic [OV_W-1:0]  OV_LAST   = OV_W'(MAX_TX_SLOTS - 1);

    state_t            state, state_d;
    logic [CLK_W-1:0]  clk_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [OV_W-1:0]   ov_cnt;
    logic              win_sel, win_sel_d;
    logic [1:0]        miss_pend, miss_pend_d;
    logic [1:0]        ack_d, status_d;
    logic              tx_start_d, tx_abort_d, tx_sel_d;

    logic [1:0]        fresh, slot_ok, tick_hit, tick_bad, sel_mask;
    logic [1:0]        new_miss, all_miss;
    logic              tx_allowed, go, win, done;
    logic [1:0]        done_code;

    assign fsm_state = state;

    // ---------------- slot timer ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_cnt     <= '0;
            slot_num    <= '0;
            slot_tick   <= 1'b0;
            sync_locked <= 1'b0;
        end else if (sync_pulse) begin
            clk_cnt     <= '0;
            slot_num    <= '0;
            slot_tick   <= 1'b1;
            sync_locked <= 1'b1;
        end else if (clk_cnt == CLK_LAST) begin
            clk_cnt   <= '0;
            slot_num  <= (slot_num == SLOT_LAST) ? 12'd0 : slot_num + 12'd1;
            slot_tick <= 1'b1;
        end else begin
            clk_cnt   <= clk_cnt + CLK_W'(1);
            slot_tick <= 1'b0;
        end
    end

    // ---------------- request qualification ----------------
    // A requester already acked or holding a deferred miss is not re-evaluated,
    // so it can never be acked twice for one request.
    assign fresh      = req & ~ack & ~miss_pend;
    assign slot_ok    = {({1'b0, req_slot1} < SLOT_LIM), ({1'b0, req_slot0} < SLOT_LIM)};
    assign tick_hit   = slot_tick ? (fresh & slot_ok &
                                     {(req_slot1 == slot_num), (req_slot0 == slot_num)}) : 2'b00;
    assign tick_bad   = slot_tick ? (fresh & ~slot_ok) : 2'b00;
    assign tx_allowed = (REQUIRE_SYNC == 0) || sync_locked;
    assign go         = (state == IDLE) && tx_allowed && (tick_hit != 2'b00);
    assign win        = ~tick_hit[0];
    assign sel_mask   = {win_sel, ~win_sel};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state;
        case (state)
            IDLE:      if (go) state_d = START;
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy)                 state_d = TX;
                else if (to_cnt == TO_LAST)  state_d = IDLE;
            end
            TX: begin
                if (!tx_busy)                             state_d = IDLE;
                else if (slot_tick && ov_cnt == OV_LAST)  state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        done       = 1'b0;
        done_code  = ST_SENT;
        tx_abort_d = 1'b0;
        tx_start_d = (state == START);
        tx_sel_d   = (state == START) ? win_sel : tx_sel;
        win_sel_d  = go ? win : win_sel;

        new_miss = tick_bad | tick_hit;
        if (go)                 new_miss = new_miss & ~{win, ~win};
        else if (state != IDLE) new_miss = new_miss & ~sel_mask;

        case (state)
            WAIT_BUSY: begin
                if (!tx_busy && to_cnt == TO_LAST) begin
                    done      = 1'b1;
                    done_code = ST_TIMEOUT;
                end
            end
            TX: begin
                if (!tx_busy) begin
                    done      = 1'b1;
                    done_code = ST_SENT;
                end else if (slot_tick && ov_cnt == OV_LAST) begin
                    done       = 1'b1;
                    done_code  = ST_ABORT;
                    tx_abort_d = 1'b1;
                end
            end
            default: ;
        endcase

        // ack_status is shared, so a miss colliding with a completion waits one cycle.
        all_miss = miss_pend | new_miss;
        if (done) begin
            ack_d       = sel_mask;
            status_d    = done_code;
            miss_pend_d = all_miss;
        end else if (all_miss != 2'b00) begin
            ack_d       = all_miss;
            status_d    = ST_MISS;
            miss_pend_d = 2'b00;
        end else begin
            ack_d       = 2'b00;
            status_d    = ST_SENT;
            miss_pend_d = 2'b00;
        end
    end

    // ---------------- transaction counters ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
            ov_cnt <= '0;
        end else begin
            to_cnt <= (state == WAIT_BUSY) ? to_cnt + TO_W'(1) : '0;
            if (state != TX)    ov_cnt <= '0;
            else if (slot_tick) ov_cnt <= ov_cnt + OV_W'(1);
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_sel    <= 1'b0;
            miss_pend  <= 2'b00;
            ack        <= 2'b00;
            ack_status <= 2'b00;
            tx_start   <= 1'b0;
            tx_abort   <= 1'b0;
            tx_sel     <= 1'b0;
        end else begin
            win_sel    <= win_sel_d;
            miss_pend  <= miss_pend_d;
            ack        <= ack_d;
            ack_status <= status_d;
            tx_start   <= tx_start_d;
            tx_abort   <= tx_abort_d;
            tx_sel     <= tx_sel_d;
        end
    end

endmodule

// File: tb/tb_ais_slot_scheduler.sv
// Directed bench for ais_slot_scheduler with a small transmitter model
// (normal, never-busy and stuck-busy behaviours).
`timescale 1ns/1ps
module tb_ais_slot_scheduler;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_TX    = 2'd3;
    localparam int XM_NORMAL = 0;
    localparam int XM_DEAD   = 1;
    localparam int XM_STUCK  = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sync_pulse;
    logic [1:0]  req;
    logic [11:0] req_slot0, req_slot1;
    logic [1:0]  ack, ack_status, fsm_state;
    logic        tx_start, tx_sel, tx_abort, tx_busy;
    logic [11:0] slot_num;
    logic        slot_tick, sync_locked;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int xm_mode = XM_NORMAL;
    int xm_phase = 0;
    int xm_cnt  = 0;

    ais_slot_scheduler #(
        .SLOT_CLKS(16), .SLOTS_PER_FRAME(8), .START_TIMEOUT(4),
        .MAX_TX_SLOTS(2), .REQUIRE_SYNC(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sync_pulse(sync_pulse),
        .req(req), .req_slot0(req_slot0), .req_slot1(req_slot1),
        .ack(ack), .ack_status(ack_status),
        .tx_start(tx_start), .tx_sel(tx_sel), .tx_abort(tx_abort), .tx_busy(tx_busy),
        .slot_num(slot_num), .slot_tick(slot_tick), .sync_locked(sync_locked),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
        $fatal(1);
    end

    // Transmitter: busy 2 clocks after tx_start, held 20 clocks (normal mode).
    always @(negedge clk) begin
        if (!reset_n) begin
            tx_busy  = 1'b0;
            xm_phase = 0;
            xm_cnt   = 0;
        end else if (tx_abort) begin
            tx_busy  = 1'b0;
            xm_phase = 0;
        end else begin
            case (xm_phase)
                0: if (tx_start && xm_mode != XM_DEAD) begin
                    xm_phase = 1;
                    xm_cnt   = 2;
                end
                1: begin
                    xm_cnt--;
                    if (xm_cnt == 0) begin
                        tx_busy  = 1'b1;
                        xm_phase = 2;
                        xm_cnt   = 20;
                    end
                end
                default: if (xm_mode == XM_NORMAL) begin
                    xm_cnt--;
                    if (xm_cnt == 0) begin
                        tx_busy  = 1'b0;
                        xm_phase = 0;
                    end
                end
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; sync_pulse = 1'b0; req = 2'b00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_tick(input int slot, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (slot_tick && (slot < 0 || slot_num == 12'(slot))) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_ack(input int bound, output bit ok, output int at);
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                ok = 1'b1;
                at = cyc;
                return;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; sync_pulse = 1'b0; req = 2'b00;
        req_slot0 = 12'd0; req_slot1 = 12'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ack, ack_status, tx_start, tx_sel, tx_abort, slot_tick, sync_locked, fsm_state} !== 11'd0) begin
            errors++;
            $display("FAIL reset_ctrl: ack=%b st=%b start=%b sel=%b abort=%b tick=%b lock=%b fsm=%b, expected all 0",
                     ack, ack_status, tx_start, tx_sel, tx_abort, slot_tick, sync_locked, fsm_state);
        end
        checks++;
        if (slot_num !== 12'd0) begin
            errors++; $display("FAIL reset_slot: slot_num=%0d expected 0", slot_num);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_unlocked();
        bit ok; int n;
        do_reset();
        req_slot0 = 12'd2; req = 2'b01;
        wait_tick(2, 300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL unlocked_tick: tick of slot 2 not seen, expected within 300 clocks"); end
        @(negedge clk);
        checks++;
        if (ack !== 2'b01 || ack_status !== 2'b01) begin
            errors++; $display("FAIL unlocked_ack: ack=%b st=%b expected ack=01 st=01", ack, ack_status);
        end
        req = 2'b00;
        n = 0;
        repeat (4) begin @(negedge clk); if (tx_start) n++; end
        checks++;
        if (n != 0) begin errors++; $display("FAIL unlocked_nostart: tx_start pulses=%0d expected 0", n); end
        checks++;
        if (fsm_state !== S_IDLE || sync_locked !== 1'b0) begin
            errors++; $display("FAIL unlocked_state: fsm=%b lock=%b expected fsm=00 lock=0", fsm_state, sync_locked);
        end
    endtask

    task automatic test_free_run_sync();
        logic [11:0] exp_slot;
        logic        exp_tick;
        do_reset();
        checks++;
        if (slot_num !== 12'd0 || slot_tick !== 1'b0) begin
            errors++; $display("FAIL freerun_k0: slot=%0d tick=%b expected slot=0 tick=0", slot_num, slot_tick);
        end
        for (int k = 1; k <= 216; k++) begin
            @(negedge clk);
            exp_slot = 12'((k / 16) % 8);
            exp_tick = (k % 16 == 0);
            checks++;
            if (slot_num !== exp_slot || slot_tick !== exp_tick) begin
                errors++;
                $display("FAIL freerun_k%0d: slot=%0d tick=%b expected slot=%0d tick=%b",
                         k, slot_num, slot_tick, exp_slot, exp_tick);
            end
        end
        sync_pulse = 1'b1;
        @(negedge clk);
        sync_pulse = 1'b0;
        checks++;
        if (slot_num !== 12'd0 || slot_tick !== 1'b1 || sync_locked !== 1'b1) begin
            errors++; $display("FAIL sync_align: slot=%0d tick=%b lock=%b expected slot=0 tick=1 lock=1",
                               slot_num, slot_tick, sync_locked);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (slot_num !== 12'd0 || slot_tick !== 1'b0) begin
            errors++; $display("FAIL sync_slot0_end: slot=%0d tick=%b expected slot=0 tick=0", slot_num, slot_tick);
        end
        @(negedge clk);
        checks++;
        if (slot_num !== 12'd1 || slot_tick !== 1'b1) begin
            errors++; $display("FAIL sync_next_tick: slot=%0d tick=%b expected slot=1 tick=1", slot_num, slot_tick);
        end
    endtask

    task automatic test_normal_send();
        bit ok; int t0, at;
        xm_mode = XM_NORMAL; req_slot0 = 12'd3; req = 2'b01;
        wait_tick(3, 300, ok);
        t0 = cyc;
        checks++;
        if (!ok) begin errors++; $display("FAIL normal_tick: tick of slot 3 not seen, expected within 300 clocks"); end
        @(negedge clk);
        checks++;
        if (ack !== 2'b00 || fsm_state !== S_START) begin
            errors++; $display("FAIL normal_decide: ack=%b fsm=%b expected ack=00 fsm=01", ack, fsm_state);
        end
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || tx_sel !== 1'b0) begin
            errors++; $display("FAIL normal_start: tx_start=%b tx_sel=%b expected 1 and 0", tx_start, tx_sel);
        end
        wait_ack(60, ok, at);
        checks++;
        if (!ok || at - t0 != 25) begin
            errors++; $display("FAIL normal_ack_time: ack at tick+%0d expected tick+25", at - t0);
        end
        checks++;
        if (ack !== 2'b01 || ack_status !== 2'b00) begin
            errors++; $display("FAIL normal_ack: ack=%b st=%b expected ack=01 st=00", ack, ack_status);
        end
        req = 2'b00;
        @(negedge clk);
        checks++;
        if (ack !== 2'b00 || fsm_state !== S_IDLE) begin
            errors++; $display("FAIL normal_after: ack=%b fsm=%b expected ack=00 fsm=00", ack, fsm_state);
        end
    endtask

    task automatic test_collision();
        bit ok; int t0, at;
        req_slot0 = 12'd2; req_slot1 = 12'd2; req = 2'b11;
        wait_tick(2, 300, ok);
        t0 = cyc;
        checks++;
        if (!ok) begin errors++; $display("FAIL coll_tick: tick of slot 2 not seen, expected within 300 clocks"); end
        @(negedge clk);
        checks++;
        if (ack !== 2'b10 || ack_status !== 2'b01) begin
            errors++; $display("FAIL coll_loser: ack=%b st=%b expected ack=10 st=01", ack, ack_status);
        end
        req = 2'b01;
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || tx_sel !== 1'b0) begin
            errors++; $display("FAIL coll_start: tx_start=%b tx_sel=%b expected 1 and 0", tx_start, tx_sel);
        end
        wait_ack(60, ok, at);
        checks++;
        if (!ok || at - t0 != 25 || ack !== 2'b01 || ack_status !== 2'b00) begin
            errors++; $display("FAIL coll_winner: ack=%b st=%b at tick+%0d expected ack=01 st=00 at tick+25",
                               ack, ack_status, at - t0);
        end
        req = 2'b00;
    endtask

    task automatic test_busy_miss();
        bit ok; int t0, at;
        req_slot0 = 12'd4; req_slot1 = 12'd5; req = 2'b11;
        wait_tick(4, 300, ok);
        t0 = cyc;
        checks++;
        if (!ok) begin errors++; $display("FAIL bmiss_tick: tick of slot 4 not seen, expected within 300 clocks"); end
        wait_ack(40, ok, at);
        checks++;
        if (!ok || at - t0 != 17 || ack !== 2'b10 || ack_status !== 2'b01) begin
            errors++; $display("FAIL bmiss_miss: ack=%b st=%b at tick+%0d expected ack=10 st=01 at tick+17",
                               ack, ack_status, at - t0);
        end
        req = 2'b01;
        wait_ack(40, ok, at);
        checks++;
        if (!ok || at - t0 != 25 || ack !== 2'b01 || ack_status !== 2'b00) begin
            errors++; $display("FAIL bmiss_sent: ack=%b st=%b at tick+%0d expected ack=01 st=00 at tick+25",
                               ack, ack_status, at - t0);
        end
        req = 2'b00;
    endtask

    task automatic test_start_timeout();
        bit ok; int t0, at;
        xm_mode = XM_DEAD; req_slot0 = 12'd6; req = 2'b01;
        wait_tick(6, 300, ok);
        t0 = cyc;
        checks++;
        if (!ok) begin errors++; $display("FAIL tmo_tick: tick of slot 6 not seen, expected within 300 clocks"); end
        wait_ack(40, ok, at);
        checks++;
        if (!ok || at - t0 != 6 || ack !== 2'b01 || ack_status !== 2'b10 || tx_abort !== 1'b0) begin
            errors++; $display("FAIL tmo_ack: ack=%b st=%b abort=%b at tick+%0d expected ack=01 st=10 abort=0 at tick+6",
                               ack, ack_status, tx_abort, at - t0);
        end
        req = 2'b00;
        xm_mode = XM_NORMAL;
    endtask

    task automatic test_overrun_abort();
        bit ok; int t0, at;
        xm_mode = XM_STUCK; req_slot0 = 12'd7; req = 2'b01;
        wait_tick(7, 300, ok);
        t0 = cyc;
        checks++;
        if (!ok) begin errors++; $display("FAIL ovr_tick: tick of slot 7 not seen, expected within 300 clocks"); end
        wait_ack(80, ok, at);
        checks++;
        if (!ok || at - t0 != 33 || ack !== 2'b01 || ack_status !== 2'b11 || tx_abort !== 1'b1) begin
            errors++; $display("FAIL ovr_abort: ack=%b st=%b abort=%b at tick+%0d expected ack=01 st=11 abort=1 at tick+33",
                               ack, ack_status, tx_abort, at - t0);
        end
        req = 2'b00;
        @(negedge clk);
        checks++;
        if (tx_abort !== 1'b0 || fsm_state !== S_IDLE) begin
            errors++; $display("FAIL ovr_after: abort=%b fsm=%b expected abort=0 fsm=00", tx_abort, fsm_state);
        end
        xm_mode = XM_NORMAL;
    endtask

    task automatic test_invalid_slot();
        bit ok;
        req_slot0 = 12'd9; req = 2'b01;
        wait_tick(-1, 40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL inv_tick: no slot tick seen, expected within 40 clocks"); end
        @(negedge clk);
        checks++;
        if (ack !== 2'b01 || ack_status !== 2'b01) begin
            errors++; $display("FAIL inv_ack: ack=%b st=%b expected ack=01 st=01", ack, ack_status);
        end
        req = 2'b00;
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0 || fsm_state !== S_IDLE) begin
            errors++; $display("FAIL inv_nostart: tx_start=%b fsm=%b expected 0 and 00", tx_start, fsm_state);
        end
    endtask

    task automatic test_reset_mid_tx();
        bit ok; int n;
        req_slot1 = 12'd2; req = 2'b10;
        wait_tick(2, 300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_tick: tick of slot 2 not seen, expected within 300 clocks"); end
        repeat (2) @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || tx_sel !== 1'b1) begin
            errors++; $display("FAIL rst_start: tx_start=%b tx_sel=%b expected 1 and 1", tx_start, tx_sel);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (fsm_state !== S_TX) begin errors++; $display("FAIL rst_in_tx: fsm=%b expected 11", fsm_state); end
        reset_n = 1'b0; req = 2'b00;
        #1;
        checks++;
        if ({ack, ack_status, tx_start, tx_sel, tx_abort, slot_tick, sync_locked, fsm_state} !== 11'd0
            || slot_num !== 12'd0) begin
            errors++;
            $display("FAIL rst_values: ack=%b st=%b start=%b sel=%b abort=%b tick=%b lock=%b fsm=%b slot=%0d, expected all 0",
                     ack, ack_status, tx_start, tx_sel, tx_abort, slot_tick, sync_locked, fsm_state, slot_num);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack != 2'b00 || tx_abort || tx_start) n++;
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL rst_quiet: %0d cycles with ack/abort/start after reset, expected 0", n); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset_n = 1'b0; sync_pulse = 1'b0; req = 2'b00;
        req_slot0 = 12'd0; req_slot1 = 12'd0;
        test_reset();
        test_unlocked();
        test_free_run_sync();
        test_normal_send();
        test_collision();
        test_busy_miss();
        test_start_timeout();
        test_overrun_abort();
        test_invalid_slot();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
